rfft_seq: RTL and testbench

RFFT_SEQ -- requirements
Module: rfft_seq

---
 rtl/rfft_seq.sv | 103 ++++++++++
 tb/tb_rfft_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rfft_seq.sv
// rfft_seq: address/control sequencer for an in-place radix-2 FFT over a bank pair.
// Optional RFFT_SEQ_ABORT_EN adds an Abort input that returns a busy sequencer to IDLE.
module rfft_seq #(
   parameter int ADDR_W = 6,
   parameter int STAGES = 7,
   parameter int PE_LAT = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
`ifdef RFFT_SEQ_ABORT_EN
   input  logic              Abort,
`endif
   output logic              Busy,
   output logic              Done,
   output logic [2:0]        Stage,
   output logic              Bypass_n,
   output logic [ADDR_W-1:0] Rd_addr0,
   output logic [ADDR_W-1:0] Rd_addr1,
   output logic              Rd_swap,
   output logic              We,
   output logic [ADDR_W-1:0] Wr_addr0,
   output logic [ADDR_W-1:0] Wr_addr1,
   output logic              Wr_swap,
   output logic [ADDR_W-1:0] Tf_addr
);
   typedef enum logic [2:0] {IDLE, RUN, DRAIN, NEXT, DONE} state_t;
   localparam logic [2:0] LAST = 3'(STAGES - 1);
   localparam logic [ADDR_W-1:0] C_MAX = '1;
   localparam logic [ADDR_W-1:0] D_MAX = ADDR_W'(PE_LAT - 1);
   state_t st, nxt;
   logic [ADDR_W-1:0] c, lo, m, tf;
   logic [2:0] stg;
   logic run, rsw, wsw, kill;
   logic vld [PE_LAT];
   logic sw_d [PE_LAT];
   logic [ADDR_W-1:0] a0_d [PE_LAT];
   logic [ADDR_W-1:0] a1_d [PE_LAT];
`ifdef RFFT_SEQ_ABORT_EN
   assign kill = Abort && st != IDLE;
`else
   assign kill = 1'b0;
`endif
   always_comb begin
      nxt = st;
      case (st)
         IDLE:    nxt = Start ? RUN : IDLE;
         RUN:     nxt = c == C_MAX ? DRAIN : RUN;
         DRAIN:   nxt = c == D_MAX ? (stg == LAST ? DONE : NEXT) : DRAIN;
         NEXT:    nxt = RUN;
         default: nxt = IDLE;
      endcase
   end
   // c counts butterflies in RUN and drain cycles in DRAIN, restarting on every state change
   always_ff @(posedge Clk) begin
      if (Reset || kill) begin
         st <= IDLE;
         c <= '0;
         stg <= '0;
         for (int i = 0; i < PE_LAT; i++) begin
            vld[i] <= 1'b0;
            sw_d[i] <= 1'b0;
            a0_d[i] <= '0;
            a1_d[i] <= '0;
         end
      end else begin
         st <= nxt;
         c <= (nxt != st || st == IDLE) ? '0 : c + 1'b1;
         stg <= nxt == IDLE ? 3'd0 : st == NEXT ? stg + 3'd1 : stg;
         vld[0] <= run;
         sw_d[0] <= run & wsw;
         a0_d[0] <= Rd_addr0;
         a1_d[0] <= Rd_addr1;
         for (int i = 1; i < PE_LAT; i++) begin
            vld[i] <= vld[i-1];
            sw_d[i] <= sw_d[i-1];
            a0_d[i] <= a0_d[i-1];
            a1_d[i] <= a1_d[i-1];
         end
      end
   end
   // lo masks the low ADDR_W-s bits; its complement is the butterfly partner mask
   always_comb begin
      run = st == RUN;
      lo = {ADDR_W{1'b1}} >> stg;
      m = ~lo;
      tf = (c & lo) << stg;
      rsw = |(c & m & ~(m << 1));
      wsw = stg != LAST && |(c & lo & ~(lo >> 1));
   end
   assign Busy = st != IDLE;
   assign Done = st == DONE;
   assign Stage = stg;
   assign Bypass_n = !(stg == LAST && st != IDLE);
   assign Rd_addr0 = run ? c : '0;
   assign Rd_addr1 = run ? c ^ m : '0;
   assign Rd_swap = run & rsw;
   assign Tf_addr = run ? tf : '0;
   assign We = vld[PE_LAT-1];
   assign Wr_swap = sw_d[PE_LAT-1];
   assign Wr_addr0 = a0_d[PE_LAT-1];
   assign Wr_addr1 = a1_d[PE_LAT-1];
endmodule

// File: tb/tb_rfft_seq.sv
// tb_rfft_seq: directed timeline checks of rfft_seq with default parameters.
module tb_rfft_seq;
   logic Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Abort = 1'b0;
   logic Busy, Done, Bypass_n, Rd_swap, We, Wr_swap;
   logic [2:0] Stage;
   logic [5:0] Rd_addr0, Rd_addr1, Wr_addr0, Wr_addr1, Tf_addr;
   int checks = 0, errors = 0;

   rfft_seq dut (
      .Clk(Clk), .Reset(Reset), .Start(Start),
`ifdef RFFT_SEQ_ABORT_EN
      .Abort(Abort),
`endif
      .Busy(Busy), .Done(Done), .Stage(Stage), .Bypass_n(Bypass_n),
      .Rd_addr0(Rd_addr0), .Rd_addr1(Rd_addr1), .Rd_swap(Rd_swap),
      .We(We), .Wr_addr0(Wr_addr0), .Wr_addr1(Wr_addr1), .Wr_swap(Wr_swap),
      .Tf_addr(Tf_addr)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start at cycle 0; stage s runs cycles 1+67s..64+67s, drains two cycles, NEXT at 67(s+1)
   task automatic run_timeline(input bit hold);
      int wes, s;
      Start = 1'b1;
      tick();
      if (!hold) Start = 1'b0;
      chk("busy_c1", Busy, 1);
      chk("we_c1", We, 0);
      wes = 0;
      for (int cyc = 2; cyc <= 470; cyc++) begin
         tick();
         if (We) wes++;
         s = (cyc - 1) / 67;
         if (s > 6) s = 6;
         if (cyc <= 469) begin
            chk("stage", Stage, s);
            chk("bypass_n", Bypass_n, s != 6);
         end
         chk("done", Done, cyc == 469);
         chk("busy", Busy, cyc <= 469);
         if (cyc % 67 == 0 && cyc <= 402) chk("we_next", We, 0);
         if (cyc == 2) chk("we_c2", We, 0);
         if (cyc == 3) begin
            chk("we_c3", We, 1);
            chk("wr_addr0_c3", Wr_addr0, 0);
         end
         if (cyc == 6) begin
            chk("s0_rd_addr1", Rd_addr1, 6'h05);
            chk("s0_rd_swap", Rd_swap, 0);
            chk("s0_tf", Tf_addr, 6'h05);
         end
         if (cyc == 40) begin
            chk("s0_wr_addr0", Wr_addr0, 6'h25);
            chk("s0_wr_swap", Wr_swap, 1);
         end
         if (cyc == 156) begin
            chk("s2_rd_addr0", Rd_addr0, 6'h15);
            chk("s2_rd_addr1", Rd_addr1, 6'h25);
            chk("s2_rd_swap", Rd_swap, 1);
            chk("s2_tf", Tf_addr, 6'h14);
         end
         if (cyc == 158) begin
            chk("s2_wr_addr1", Wr_addr1, 6'h25);
            chk("s2_wr_swap", Wr_swap, 0);
         end
         if (cyc == 424) begin
            chk("s6_rd_addr1", Rd_addr1, 6'h2A);
            chk("s6_rd_swap", Rd_swap, 1);
            chk("s6_tf", Tf_addr, 0);
         end
         if (cyc == 426) chk("s6_wr_swap", Wr_swap, 0);
         if (cyc == 470) begin
            chk("idle_stage", Stage, 0);
            chk("idle_bypass_n", Bypass_n, 1);
            chk("idle_we", We, 0);
         end
      end
      chk("we_count", wes, 448);
   endtask

   initial begin
      tick();
      tick();
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_we", We, 0);
      chk("rst_bypass_n", Bypass_n, 1);
      chk("rst_rd_addr1", Rd_addr1, 0);
      chk("rst_tf", Tf_addr, 0);
      Reset = 1'b0;
      tick();
      chk("idle_busy", Busy, 0);
      run_timeline(0);

      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 2; i <= 212; i++) tick();
      chk("mid_stage", Stage, 3);
      chk("mid_c", Rd_addr0, 10);
      Reset = 1'b1;
      Start = 1'b1;
      tick();
      chk("mrst_busy", Busy, 0);
      chk("mrst_we", We, 0);
      chk("mrst_stage", Stage, 0);
      chk("mrst_done", Done, 0);
      chk("mrst_rd_addr1", Rd_addr1, 0);
      chk("mrst_bypass_n", Bypass_n, 1);
      Reset = 1'b0;
      Start = 1'b0;
      tick();
      chk("rst_start_ignored", Busy, 0);
      chk("post_rst_we", We, 0);
      run_timeline(0);

      run_timeline(1);
      tick();
      chk("hold_restart_busy", Busy, 1);
      chk("hold_restart_stage", Stage, 0);
      chk("hold_restart_c", Rd_addr0, 0);
      Start = 1'b0;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      tick();
      chk("hold_cleanup", Busy, 0);

`ifdef RFFT_SEQ_ABORT_EN
      Abort = 1'b1;
      tick();
      chk("abort_idle", Busy, 0);
      Abort = 1'b0;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 2; i <= 100; i++) tick();
      chk("pre_abort_busy", Busy, 1);
      Abort = 1'b1;
      tick();
      chk("abort_busy", Busy, 0);
      chk("abort_we", We, 0);
      chk("abort_done", Done, 0);
      Abort = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("abort_no_done", Done, 0);
         chk("abort_no_we", We, 0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
